// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the RV32 pipeline datapath and the hazard controller.
// The datapath side is the master and the controller is the slave.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic              IsMdD;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [REG_AW-1:0] RdE;
    logic              MemReadE;
    logic              MdStartE;
    logic              PCSrcE;
    logic              ExtFlush;
    logic [REG_AW-1:0] RdM;
    logic              RegWriteM;
    logic [REG_AW-1:0] RdW;
    logic              RegWriteW;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic              MdBusy;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output Rs1D, Rs2D, IsMdD, Rs1E, Rs2E, RdE, MemReadE, MdStartE,
               PCSrcE, ExtFlush, RdM, RegWriteM, RdW, RegWriteW,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               MdBusy, StallCount
    );

    modport slave (
        input  Rs1D, Rs2D, IsMdD, Rs1E, Rs2E, RdE, MemReadE, MdStartE,
               PCSrcE, ExtFlush, RdM, RegWriteM, RdW, RegWriteW,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               MdBusy, StallCount
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 core: forwarding, load-use stall,
// flushes, a one-entry MUL/DIV scoreboard and a saturating stall counter.
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hif
);
    localparam int MDC_W = $clog2(MD_LATENCY) + 1;

    logic              md_busy_q, md_busy_d;
    logic [MDC_W-1:0]  md_cnt_q,  md_cnt_d;
    logic [REG_AW-1:0] md_rd_q,   md_rd_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic lw_stall_s;
    logic md_raw_s;
    logic md_struct_s;
    logic stall_s;
    logic stall_d_s;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] rd_w
    );
        logic [1:0] sel;
        if (wr_m && (rd_m != {REG_AW{1'b0}}) && (rd_m == rs)) begin
            sel = 2'b10;
        end else if (wr_w && (rd_w != {REG_AW{1'b0}}) && (rd_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    assign hif.ForwardAE = fwd_sel(hif.Rs1E, hif.RegWriteM, hif.RdM, hif.RegWriteW, hif.RdW);
    assign hif.ForwardBE = fwd_sel(hif.Rs2E, hif.RegWriteM, hif.RdM, hif.RegWriteW, hif.RdW);

    // Decode-stage hazard detection; x0 as a destination never creates a dependency.
    always_comb begin
        lw_stall_s  = hif.MemReadE && (hif.RdE != {REG_AW{1'b0}}) &&
                      ((hif.RdE == hif.Rs1D) || (hif.RdE == hif.Rs2D));
        md_raw_s    = md_busy_q && (md_rd_q != {REG_AW{1'b0}}) &&
                      ((md_rd_q == hif.Rs1D) || (md_rd_q == hif.Rs2D));
        md_struct_s = md_busy_q && hif.IsMdD;
        stall_s     = lw_stall_s || md_raw_s || md_struct_s;
        stall_d_s   = stall_s && !hif.ExtFlush;
    end

    assign hif.StallF     = stall_d_s;
    assign hif.StallD     = stall_d_s;
    assign hif.FlushD     = hif.PCSrcE || hif.ExtFlush;
    assign hif.FlushE     = stall_s || hif.PCSrcE || hif.ExtFlush;
    assign hif.MdBusy     = md_busy_q;
    assign hif.StallCount = stall_cnt_q;

    // Scoreboard next state: a flush cancels, a busy unit counts down, an idle unit accepts an issue.
    always_comb begin
        md_busy_d = md_busy_q;
        md_cnt_d  = md_cnt_q;
        md_rd_d   = md_rd_q;
        if (hif.ExtFlush) begin
            md_busy_d = 1'b0;
            md_cnt_d  = {MDC_W{1'b0}};
        end else if (md_busy_q) begin
            if (md_cnt_q == {MDC_W{1'b0}}) begin
                md_busy_d = 1'b0;
            end else begin
                md_cnt_d = md_cnt_q - MDC_W'(1);
            end
        end else if (hif.MdStartE) begin
            md_busy_d = 1'b1;
            md_cnt_d  = MDC_W'(MD_LATENCY - 1);
            md_rd_d   = hif.RdE;
        end else begin
            md_busy_d = md_busy_q;
        end
    end

    // Stall performance counter, pinned at all-ones once saturated.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_d_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_busy_q   <= 1'b0;
            md_cnt_q    <= {MDC_W{1'b0}};
            md_rd_q     <= {REG_AW{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            md_busy_q   <= md_busy_d;
            md_cnt_q    <= md_cnt_d;
            md_rd_q     <= md_rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle-level model of the hazard rules
// checked every cycle, plus hand-computed expectations on directed vectors.
module tb_hazard_ctrl;
    localparam int REG_AW = 5;
    localparam int MD_LAT = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   chk_en;

    // Model state: remaining busy cycles of the MUL/DIV, its destination, stall count.
    int   m_left;
    int   m_rd;
    int   m_cnt;

    hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(32)) h  ();
    hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(3))  h3 ();

    hazard_ctrl #(.REG_AW(REG_AW), .MD_LATENCY(MD_LAT), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .hif (h)
    );

    hazard_ctrl #(.REG_AW(REG_AW), .MD_LATENCY(MD_LAT), .CNT_W(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .hif (h3)
    );

    assign h3.Rs1D      = h.Rs1D;
    assign h3.Rs2D      = h.Rs2D;
    assign h3.IsMdD     = h.IsMdD;
    assign h3.Rs1E      = h.Rs1E;
    assign h3.Rs2E      = h.Rs2E;
    assign h3.RdE       = h.RdE;
    assign h3.MemReadE  = h.MemReadE;
    assign h3.MdStartE  = h.MdStartE;
    assign h3.PCSrcE    = h.PCSrcE;
    assign h3.ExtFlush  = h.ExtFlush;
    assign h3.RdM       = h.RdM;
    assign h3.RegWriteM = h.RegWriteM;
    assign h3.RdW       = h.RdW;
    assign h3.RegWriteW = h.RegWriteW;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fwd_exp(input int rs);
        if (h.RegWriteM && h.RdM != 0 && int'(h.RdM) == rs) return 2;
        if (h.RegWriteW && h.RdW != 0 && int'(h.RdW) == rs) return 1;
        return 0;
    endfunction

    function automatic bit stall_exp();
        bit lw, raw, st;
        lw  = h.MemReadE && h.RdE != 0 && (h.RdE == h.Rs1D || h.RdE == h.Rs2D);
        raw = (m_left > 0) && m_rd != 0 && (m_rd == int'(h.Rs1D) || m_rd == int'(h.Rs2D));
        st  = (m_left > 0) && h.IsMdD;
        return lw || raw || st;
    endfunction

    // Model update on every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_rd   = 0;
            m_cnt  = 0;
        end else begin
            if (stall_exp() && !h.ExtFlush) m_cnt = m_cnt + 1;
            if (h.MdStartE) begin
                total++;
                if (m_left > 0 && !h.ExtFlush) begin
                    bad++;
                    $display("FAIL md_protocol: MdStartE=1 while busy (left=%0d) expected idle", m_left);
                end
            end
            if (h.ExtFlush) begin
                m_left = 0;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
            end else if (h.MdStartE) begin
                m_left = MD_LAT;
                m_rd   = int'(h.RdE);
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit s, sd;
            int c3;
            s  = stall_exp();
            sd = s && !h.ExtFlush;
            c3 = (m_cnt > 7) ? 7 : m_cnt;
            chk("m_fwdA",  32'(h.ForwardAE), 32'(fwd_exp(int'(h.Rs1E))));
            chk("m_fwdB",  32'(h.ForwardBE), 32'(fwd_exp(int'(h.Rs2E))));
            chk("m_stallF", 32'(h.StallF), 32'(sd));
            chk("m_stallD", 32'(h.StallD), 32'(sd));
            chk("m_flushD", 32'(h.FlushD), 32'(h.PCSrcE || h.ExtFlush));
            chk("m_flushE", 32'(h.FlushE), 32'(s || h.PCSrcE || h.ExtFlush));
            chk("m_busy",   32'(h.MdBusy), 32'(m_left > 0));
            chk("m_cnt",    h.StallCount, 32'(m_cnt));
            chk("m_stallD3", 32'(h3.StallD), 32'(sd));
            chk("m_busy3",   32'(h3.MdBusy), 32'(m_left > 0));
            chk("m_cnt3",    32'(h3.StallCount), 32'(c3));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        h.Rs1D = '0; h.Rs2D = '0; h.IsMdD = 1'b0; h.Rs1E = '0; h.Rs2E = '0;
        h.RdE = '0; h.MemReadE = 1'b0; h.MdStartE = 1'b0; h.PCSrcE = 1'b0;
        h.ExtFlush = 1'b0; h.RdM = '0; h.RegWriteM = 1'b0; h.RdW = '0; h.RegWriteW = 1'b0;
    endtask

    initial begin
        int n_stall, n_busy;
        total = 0; bad = 0; chk_en = 1'b0;
        m_left = 0; m_rd = 0; m_cnt = 0;
        clr();
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("rst_busy", 32'(h.MdBusy), 32'd0);
        chk("rst_cnt", h.StallCount, 32'd0);
        chk("rst_fwdA", 32'(h.ForwardAE), 32'd0);
        chk("rst_stall", 32'(h.StallD), 32'd0);
        chk("rst_flushE", 32'(h.FlushE), 32'd0);

        // Forwarding priority on both operands.
        h.Rs1E = 5'd5; h.RdM = 5'd5; h.RdW = 5'd5; h.RegWriteM = 1'b1; h.RegWriteW = 1'b1;
        #2; chk("fwdA_M", 32'(h.ForwardAE), 32'd2);
        tick(); h.RegWriteM = 1'b0;
        #2; chk("fwdA_W", 32'(h.ForwardAE), 32'd1);
        tick(); h.RegWriteM = 1'b1; h.RdM = 5'd0; h.RdW = 5'd0;
        #2; chk("fwdA_x0", 32'(h.ForwardAE), 32'd0);
        tick(); h.Rs1E = 5'd0; h.Rs2E = 5'd5; h.RdM = 5'd5; h.RdW = 5'd5;
        #2; chk("fwdB_M", 32'(h.ForwardBE), 32'd2);
        tick(); h.RegWriteM = 1'b0;
        #2; chk("fwdB_W", 32'(h.ForwardBE), 32'd1);
        tick(); h.RegWriteM = 1'b1; h.RdM = 5'd0; h.RdW = 5'd0;
        #2; chk("fwdB_x0", 32'(h.ForwardBE), 32'd0);
        tick(); clr();

        // Load-use stall.
        h.MemReadE = 1'b1; h.RdE = 5'd7; h.Rs2D = 5'd7;
        #2;
        chk("lu_stallF", 32'(h.StallF), 32'd1);
        chk("lu_stallD", 32'(h.StallD), 32'd1);
        chk("lu_flushE", 32'(h.FlushE), 32'd1);
        chk("lu_flushD", 32'(h.FlushD), 32'd0);
        tick(); h.RdE = 5'd0;
        #2; chk("lu_x0", 32'(h.StallD), 32'd0);
        tick(); clr();

        // MUL/DIV RAW: exactly MD_LAT stall and busy cycles.
        rst = 1'b1; tick(); rst = 1'b0;
        h.MdStartE = 1'b1; h.RdE = 5'd9;
        tick(); clr(); h.Rs1D = 5'd9;
        n_stall = 0; n_busy = 0;
        for (int i = 0; i < 6; i++) begin
            #2;
            n_stall += int'(h.StallD);
            n_busy  += int'(h.MdBusy);
            tick();
        end
        chk("raw_stalls", 32'(n_stall), 32'd4);
        chk("raw_busy", 32'(n_busy), 32'd4);
        chk("raw_cnt", h.StallCount, 32'd4);
        clr();

        // Structural stall, then cancel by ExtFlush.
        h.MdStartE = 1'b1; h.RdE = 5'd3;
        tick(); clr(); h.IsMdD = 1'b1;
        #2; chk("st_stall", 32'(h.StallD), 32'd1);
        tick(); h.ExtFlush = 1'b1;
        #2;
        chk("xf_flushD", 32'(h.FlushD), 32'd1);
        chk("xf_flushE", 32'(h.FlushE), 32'd1);
        chk("xf_stallD", 32'(h.StallD), 32'd0);
        tick(); clr();
        #2; chk("xf_busy", 32'(h.MdBusy), 32'd0);
        tick();

        // Branch resolved during a load-use stall.
        h.MemReadE = 1'b1; h.RdE = 5'd7; h.Rs1D = 5'd7; h.PCSrcE = 1'b1;
        #2;
        chk("br_flushD", 32'(h.FlushD), 32'd1);
        chk("br_flushE", 32'(h.FlushE), 32'd1);
        chk("br_stallF", 32'(h.StallF), 32'd1);
        tick(); clr();

        // Reset in the middle of a MUL/DIV.
        h.MdStartE = 1'b1; h.RdE = 5'd4;
        tick(); clr(); h.IsMdD = 1'b1;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; clr();
        #2;
        chk("rm_busy", 32'(h.MdBusy), 32'd0);
        chk("rm_cnt", h.StallCount, 32'd0);
        chk("rm_cnt3", 32'(h3.StallCount), 32'd0);
        tick();

        // Ten stall cycles: narrow counter saturates at 7.
        h.MemReadE = 1'b1; h.RdE = 5'd7; h.Rs1D = 5'd7;
        for (int i = 0; i < 10; i++) tick();
        clr();
        #2;
        chk("sat_cnt3", 32'(h3.StallCount), 32'd7);
        chk("sat_cnt", h.StallCount, 32'd10);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage RV32 core: operand forwarding to Execute, load-use stall, branch/external flush, and a scoreboard for one multi-cycle MUL/DIV unit.
- Tracks the in-flight MUL/DIV destination with a latency counter and stalls dependent or structurally conflicting instructions in Decode.
- Keeps a saturating stall-cycle performance counter.
- Sits beside the datapath; all control outputs feed the F/D/E pipeline registers.

Parameters:
REG_AW, 5, register address width
MD_LATENCY, 4, cycles the MUL/DIV unit is busy after issue (>=1)
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
Rs1D  in  REG_AW  Decode source 1
Rs2D  in  REG_AW  Decode source 2
IsMdD  in  1  Decode instruction is MUL/DIV
Rs1E  in  REG_AW  Execute source 1
Rs2E  in  REG_AW  Execute source 2
RdE  in  REG_AW  Execute destination
MemReadE  in  1  Execute instruction is a load
MdStartE  in  1  MUL/DIV issues from Execute this cycle
PCSrcE  in  1  taken branch/jump resolved in Execute
ExtFlush  in  1  trap/external flush request
RdM  in  REG_AW  Memory destination
RegWriteM  in  1  Memory writes register file
RdW  in  REG_AW  Writeback destination
RegWriteW  in  1  Writeback writes register file
ForwardAE  out  2  operand A select: 00 regfile, 10 from M, 01 from W
ForwardBE  out  2  operand B select, same encoding
StallF  out  1  hold PC
StallD  out  1  hold F/D register
FlushD  out  1  clear F/D register
FlushE  out  1  clear D/E register (bubble)
MdBusy  out  1  MUL/DIV in flight
StallCount  out  CNT_W  cycles with StallD=1, saturating

Behaviour:
- Single clock domain; reset is synchronous and active-high, using clk and rst.
- Forwarding (combinational): ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E; else 01 if RegWriteW && RdW!=0 && RdW==Rs1E; else 00. ForwardBE is identical on Rs2E. M has priority over W.
- lwStall = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- Scoreboard state: md_busy, md_cnt (width clog2(MD_LATENCY)+1), md_rd.
- Issue: on a clock edge with MdStartE=1, md_busy=0, ExtFlush=0: md_busy<=1, md_cnt<=MD_LATENCY-1, md_rd<=RdE.
- While md_busy: md_cnt decrements each cycle. At md_cnt==0 on an edge, md_busy<=0. MdBusy is therefore high for exactly MD_LATENCY cycles after issue.
- MdStartE while md_busy is ignored (no state change). The bench flags it as a protocol error; the structural stall prevents it.
- mdRaw = md_busy && md_rd!=0 && (md_rd==Rs1D || md_rd==Rs2D).
- mdStruct = md_busy && IsMdD.
- stall = lwStall | mdRaw | mdStruct.
- StallF = StallD = stall && !ExtFlush.
- FlushD = PCSrcE | ExtFlush.
- FlushE = stall | PCSrcE | ExtFlush.
- PCSrcE with stall in the same cycle: flush wins for D. StallF stays asserted; the PC mux gives the branch target priority.
- ExtFlush also clears the scoreboard on the next edge (md_busy<=0, md_cnt<=0), cancelling the in-flight MUL/DIV.
- StallCount increments on each edge where StallD=1. It holds at 2^CNT_W-1 and never wraps.
- Reset: on an edge with rst=1, md_busy, md_cnt, md_rd and StallCount all go to 0. rst has priority over MdStartE and ExtFlush; reset mid-operation aborts the MUL/DIV.
- After reset: MdBusy=0, StallCount=0. Combinational outputs follow the inputs with cleared state (all zero inputs give Forward*=00, stalls/flushes 0).
- Latency: forwarding, stall and flush outputs are same-cycle combinational. Scoreboard effects appear the cycle after the issue edge.

Test Plan:
- Forward priority: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Set RdM=RdW=0 -> 00. Repeat on Rs2E/ForwardBE.
- Load-use: MemReadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0. RdE=0 -> no stall.
- MUL/DIV RAW, MD_LATENCY=4: MdStartE with RdE=9, then Rs1D=9 held -> StallD high for exactly 4 cycles, MdBusy high for the same 4 cycles, StallCount=4.
- Structural and cancel: issue MUL/DIV, then IsMdD=1 -> stall. Pulse ExtFlush in busy cycle 2 -> FlushD=FlushE=1, StallD=0 that cycle, MdBusy=0 the next cycle.
- Branch during stall: lwStall active and PCSrcE=1 -> FlushD=1, FlushE=1.
- Reset mid-op and saturation: rst during busy -> MdBusy=0, StallCount=0 the next cycle. With CNT_W=3 and 10 stall cycles -> StallCount holds at 7.
